baud_tick_gen: RTL

Fractional baud-rate tick generator that runs in the synthesized 288 MHz domain and divides that clock down to the UART's 16x oversample and 1x bit-rate strobes. It consumes the clock synthesizer's `stable` (MMCM locked) flag, withholds ticks until lock is held, and drops back to a safe state on loss of lock. Its strobes feed the UART TX and RX controllers. Divisor changes arrive at runtime through a valid/ready handshake and are applied only on bit boundaries.

---
 rtl/baud_pkg.sv | 9 +
 rtl/baud_tick_gen_if.sv | 17 +
 rtl/baud_tick_gen_sync_2ff.sv | 13 +
 rtl/baud_tick_gen.sv | 112 +++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// baud_pkg: shared state encoding and default ratio/settle constants for the baud tick generator
package baud_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
    localparam int DEF_DEN_W         = 16;
    localparam int DEF_INIT_NUM      = 4;
    localparam int DEF_INIT_DEN      = 625;
    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int OSR               = 16;
endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: ratio config handshake plus the tick strobes fed to the UART controllers
interface baud_tick_gen_if
    import baud_pkg::*;
#(
    parameter int DEN_W = DEF_DEN_W
);
    logic             cfg_valid;
    logic [DEN_W-1:0] cfg_num;
    logic [DEN_W-1:0] cfg_den;
    logic             cfg_ready;
    logic             cfg_err;
    logic             os_tick;
    logic             bit_tick;
    logic             running;
    modport master (output cfg_valid, cfg_num, cfg_den, input cfg_ready, cfg_err, os_tick, bit_tick, running);
    modport slave  (input cfg_valid, cfg_num, cfg_den, output cfg_ready, cfg_err, os_tick, bit_tick, running);
endinterface

// File: rtl/baud_tick_gen_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, m} <= 2'b00;
        else        {q, m} <= {m, d};
    end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional num/den accumulator producing 16x and 1x UART strobes once the MMCM lock has settled
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DEN_W         = DEF_DEN_W,
    parameter int INIT_NUM      = DEF_INIT_NUM,
    parameter int INIT_DEN      = DEF_INIT_DEN,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input logic            CLK288MHZ,
    input logic            reset,
    input logic            stable,
    baud_tick_gen_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int OW = $clog2(OSR);
    state_t           state, state_nx;
    logic             lock_s;
    logic [DEN_W-1:0] acc, acc_nx, num, num_nx, den, den_nx, pnum, pnum_nx, pden, pden_nx;
    logic [DEN_W:0]   sum;
    logic [OW-1:0]    osc, osc_nx;
    logic [SW-1:0]    scnt, scnt_nx;
    logic             pend, pend_nx, xfer, legal, tick, wrap, os_q, bit_q, err_q;

    sync_2ff u_sync (.clk(CLK288MHZ), .rst_n(reset), .d(stable), .q(lock_s));

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, num};
        xfer     = bus.cfg_valid && !pend;
        legal    = bus.cfg_num != '0 && bus.cfg_num <= bus.cfg_den;
        tick     = state == RUN && lock_s && sum >= {1'b0, den};
        wrap     = tick && osc == OW'(OSR - 1);
        state_nx = state;
        acc_nx   = acc;
        osc_nx   = osc;
        scnt_nx  = scnt;
        num_nx   = num;
        den_nx   = den;
        pnum_nx  = pnum;
        pden_nx  = pden;
        pend_nx  = pend;
        case (state)
            WAIT_LOCK: begin
                scnt_nx  = '0;
                state_nx = lock_s ? SETTLE : WAIT_LOCK;
            end
            SETTLE: begin
                scnt_nx  = scnt + 1'b1;
                state_nx = !lock_s ? WAIT_LOCK : scnt == SW'(SETTLE_CYCLES - 1) ? RUN : SETTLE;
            end
            RUN: begin
                state_nx = lock_s ? RUN : WAIT_LOCK;
                acc_nx   = !lock_s ? '0 : tick ? DEN_W'(sum - {1'b0, den}) : sum[DEN_W-1:0];
                osc_nx   = !lock_s ? '0 : tick ? osc + 1'b1 : osc;
            end
            default: state_nx = WAIT_LOCK;
        endcase
        // A pending ratio swaps in on a bit boundary (restarting the phase) or when RUN is abandoned
        if (pend && (wrap || (state == RUN && !lock_s))) begin
            num_nx  = pnum;
            den_nx  = pden;
            pend_nx = 1'b0;
            if (wrap) acc_nx = '0;
        end
        if (xfer && legal) begin
            if (state == RUN && lock_s) begin
                pnum_nx = bus.cfg_num;
                pden_nx = bus.cfg_den;
                pend_nx = 1'b1;
            end else begin
                num_nx = bus.cfg_num;
                den_nx = bus.cfg_den;
            end
        end
    end

    always_ff @(posedge CLK288MHZ or negedge reset) begin
        if (!reset) begin
            state <= WAIT_LOCK;
            acc   <= '0;
            osc   <= '0;
            scnt  <= '0;
            num   <= DEN_W'(INIT_NUM);
            den   <= DEN_W'(INIT_DEN);
            pnum  <= '0;
            pden  <= '0;
            pend  <= 1'b0;
            os_q  <= 1'b0;
            bit_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            osc   <= osc_nx;
            scnt  <= scnt_nx;
            num   <= num_nx;
            den   <= den_nx;
            pnum  <= pnum_nx;
            pden  <= pden_nx;
            pend  <= pend_nx;
            os_q  <= tick;
            bit_q <= wrap;
            err_q <= xfer && !legal;
        end
    end

    assign bus.cfg_ready = !pend;
    assign bus.cfg_err   = err_q;
    assign bus.os_tick   = os_q;
    assign bus.bit_tick  = bit_q;
    assign bus.running   = state == RUN;
endmodule
